// File: rtl/four_bit_adder_pkg.sv
// Shared constants and helpers for the ripple-carry adder block.
package four_bit_adder_pkg;

   localparam int ADD_WIDTH = 4;

   // Two's-complement overflow: carry into the MSB differs from carry out of it.
   function automatic logic signed_ovf(input logic carry_msb, input logic carry_prev);
      return carry_msb ^ carry_prev;
   endfunction

endpackage

// File: rtl/four_bit_adder_if.sv
// Operand/result bundle between an adder and its driver.
interface four_bit_adder_if #(
   parameter int WIDTH = four_bit_adder_pkg::ADD_WIDTH
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             out_valid;

   modport master (
      output a, b, cin, in_valid,
      input  sum, cout, sum_q, cout_q, ovf_q, out_valid
   );

   modport slave (
      input  a, b, cin, in_valid,
      output sum, cout, sum_q, cout_q, ovf_q, out_valid
   );
endinterface

// File: rtl/four_bit_adder_full_adder_bit.sv
// Single-bit full adder, one stage of the ripple chain.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic half_s;

   assign half_s = a ^ b;
   assign s      = half_s ^ ci;
   assign co     = (a & b) | (ci & half_s);
endmodule

// File: rtl/four_bit_adder.sv
// Ripple-carry adder with a combinational result and a registered,
// valid-qualified copy carrying signed overflow.
module four_bit_adder
   import four_bit_adder_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input logic             clk,
   input logic             rst_n,
   four_bit_adder_if.slave bus
);
   logic [WIDTH:0]   carry_s;
   logic [WIDTH-1:0] sum_s;
   logic             ovf_s;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             valid_r;

   assign carry_s[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder_bit u_fa (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (carry_s[i]),
         .s  (sum_s[i]),
         .co (carry_s[i+1])
      );
   end

   assign ovf_s = signed_ovf(carry_s[WIDTH], carry_s[WIDTH-1]);

   // Capture the result on valid input; hold data and drop valid otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else if (bus.in_valid) begin
         sum_r   <= sum_s;
         cout_r  <= carry_s[WIDTH];
         ovf_r   <= ovf_s;
         valid_r <= 1'b1;
      end else begin
         valid_r <= 1'b0;
      end
   end

   assign bus.sum       = sum_s;
   assign bus.cout      = carry_s[WIDTH];
   assign bus.sum_q     = sum_r;
   assign bus.cout_q    = cout_r;
   assign bus.ovf_q     = ovf_r;
   assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: exhaustive combinational sweep plus
// directed registered-path vectors checked by an out_valid-driven monitor.
module tb_four_bit_adder;
   typedef struct packed {
      logic [3:0] s;
      logic       c;
      logic       o;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb_q[$];

   four_bit_adder_if #(.WIDTH(4)) bus ();

   four_bit_adder #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = c;
      bus.in_valid = v;
   endtask

   // Hand-computed registered vectors: a, b, cin, sum, cout, ovf.
   localparam int NDIR = 8;
   logic [3:0] d_a [NDIR] = '{4'b0111, 4'b1000, 4'b0011, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1010};
   logic [3:0] d_b [NDIR] = '{4'b0001, 4'b1000, 4'b0010, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0111};
   logic       d_ci[NDIR] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
   logic [3:0] d_s [NDIR] = '{4'b1000, 4'b0000, 4'b0101, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0010};
   logic       d_co[NDIR] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};
   logic       d_ov[NDIR] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0};

   // Streaming a=b=i: sum = 2i, ovf once 2i reaches 8.
   logic [3:0] st_s [8] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
   logic       st_ov[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      exp_t e;
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      drive(4'd0, 4'd0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("reset_sum_q", 32'(bus.sum_q), 32'd0);
      check("reset_cout_q", 32'(bus.cout_q), 32'd0);
      check("reset_ovf_q", 32'(bus.ovf_q), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);

      fork
         forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check("mon_unexpected_valid", 32'(bus.out_valid), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("mon_sum_q", 32'(bus.sum_q), 32'(e.s));
                  check("mon_cout_q", 32'(bus.cout_q), 32'(e.c));
                  check("mon_ovf_q", 32'(bus.ovf_q), 32'(e.o));
               end
            end
         end
      join_none

      @(negedge clk);
      rst_n = 1'b1;

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               drive(4'(ai), 4'(bi), 1'(ci), 1'b0);
               #10;
               check("comb_sum_cout", {27'd0, bus.cout, bus.sum}, 32'(ai + bi + ci));
            end
         end
      end
      drive(4'b1010, 4'b0111, 1'b1, 1'b0);
      #10;
      check("comb_example_sum", 32'(bus.sum), 32'h2);
      check("comb_example_cout", 32'(bus.cout), 32'h1);

      // Back-to-back directed vectors through the registered path.
      @(negedge clk);
      for (int i = 0; i < NDIR; i++) begin
         drive(d_a[i], d_b[i], d_ci[i], 1'b1);
         sb_q.push_back('{s: d_s[i], c: d_co[i], o: d_ov[i]});
         if (i > 0) check("dir_out_valid", 32'(bus.out_valid), 32'd1);
         @(negedge clk);
      end
      drive(4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("dir_drain_valid", 32'(bus.out_valid), 32'd0);

      // Latency and hold behaviour.
      drive(4'd3, 4'd4, 1'b0, 1'b1);
      sb_q.push_back('{s: 4'd7, c: 1'b0, o: 1'b0});
      @(negedge clk);
      check("lat_sum_q", 32'(bus.sum_q), 32'd7);
      check("lat_out_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("hold_sum_q", 32'(bus.sum_q), 32'd7);
      check("hold_out_valid", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset between edges; a capture during reset is discarded.
      #2 rst_n = 1'b0;
      #1;
      check("areset_sum_q", 32'(bus.sum_q), 32'd0);
      check("areset_cout_q", 32'(bus.cout_q), 32'd0);
      check("areset_ovf_q", 32'(bus.ovf_q), 32'd0);
      check("areset_out_valid", 32'(bus.out_valid), 32'd0);
      check("areset_comb_sum", 32'(bus.sum), 32'd7);
      drive(4'd5, 4'd6, 1'b0, 1'b1);
      @(negedge clk);
      check("areset_discard_valid", 32'(bus.out_valid), 32'd0);
      check("areset_discard_sum_q", 32'(bus.sum_q), 32'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("release_valid", 32'(bus.out_valid), 32'd0);

      // Streaming eight consecutive results.
      for (int i = 0; i < 8; i++) begin
         drive(4'(i), 4'(i), 1'b0, 1'b1);
         sb_q.push_back('{s: st_s[i], c: 1'b0, o: st_ov[i]});
         if (i > 0) check("stream_out_valid", 32'(bus.out_valid), 32'd1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("stream_last_valid", 32'(bus.out_valid), 32'd1);
      check("stream_last_sum_q", 32'(bus.sum_q), 32'd14);
      @(negedge clk);
      check("stream_end_valid", 32'(bus.out_valid), 32'd0);

      for (int w = 0; w < 4 && sb_q.size() != 0; w++) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
